tx_feeder: RTL and testbench

- Single-clock staging buffer directly upstream of dclk_tx, in the writer-clock domain.
- Accepts flits (address + payload) from the router/injector side into a small FIFO.
- Presents each flit on parallel_out with a one-cycle req pulse, then waits for dclk_tx to finish serialising it (tx_busy high, then low) before issuing the next.
- Removes the need for the producer to track link occupancy; dclk_tx sees at most one outstanding request.

---
 rtl/tx_feeder_pkg.sv | 39 +++
 rtl/tx_feeder_sync_fifo.sv | 79 +++++++
 rtl/tx_feeder.sv | 101 ++++++++++
 tb/tb_tx_feeder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_feeder_pkg
//  Description : Shared flit geometry and feeder state encodings. The state
//                codes are also exposed as macros so debug monitors can
//                decode the feeder state without importing the package.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif
`ifndef TXF_IDLE
`define TXF_IDLE       2'd0
`define TXF_REQ        2'd1
`define TXF_WAIT_START 2'd2
`define TXF_WAIT_DONE  2'd3
`endif

package tx_feeder_pkg;

    // Flit = address + payload; must match the serialiser's parallel input.
    localparam int FLIT_WIDTH   = `PAYLOAD_SIZE + `ADDR_BITS;
    localparam int FIFO_DEPTH   = 4;
    localparam int FIFO_PTR_BITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE       = `TXF_IDLE,
        ST_REQ        = `TXF_REQ,
        ST_WAIT_START = `TXF_WAIT_START,
        ST_WAIT_DONE  = `TXF_WAIT_DONE
    } txf_state_t;

endpackage

`default_nettype wire

// File: rtl/tx_feeder_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO holding flits for the feeder. Occupancy is
//                tracked with an explicit count so full and empty stay
//                distinguishable when the pointers coincide after a wrap.
//                Writes while full are dropped and flagged stickily.
//  Revision    : 1.0 - initial release
// ============================================================================

module sync_fifo #(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2,
    parameter int WIDTH    = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    data_in,
    input  logic                pop,
    output logic [WIDTH-1:0]    head,
    output logic                full,
    output logic                empty,
    output logic [PTR_BITS:0]   count,
    output logic                overflow
);

    localparam logic [PTR_BITS:0] DEPTH_CNT = (PTR_BITS+1)'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                push;
    logic                do_pop;

    // full/empty come straight from the registered count, so a write in the
    // same cycle as a pop is still refused when the FIFO was full pre-edge.
    assign full   = (count == DEPTH_CNT);
    assign empty  = (count == '0);
    assign push   = wr_en && !full;
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    // Storage is deliberately left out of reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Power-of-two depth: natural pointer rollover gives modulo DEPTH.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tx_feeder
//  Description : Staging buffer in front of the serialiser. Queues flits from
//                the producer and hands them over one at a time: a one-cycle
//                req pulse with the flit on parallel_out, then waits for the
//                serialiser's busy indication to rise and fall before the
//                next flit is offered. sent pulses when a flit is delivered.
//  Revision    : 1.0 - initial release
// ============================================================================

module tx_feeder
    import tx_feeder_pkg::*;
#(
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int PTR_BITS = FIFO_PTR_BITS,
    parameter int WIDTH    = FLIT_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    data_in,
    output logic                full,
    output logic [PTR_BITS:0]   count,
    output logic                overflow,
    output logic                req,
    output logic [WIDTH-1:0]    parallel_out,
    input  logic                tx_busy,
    output logic                sent
);

    txf_state_t       state;
    logic [WIDTH-1:0] head;
    logic             empty;
    logic             pop;

    // A flit leaves the FIFO on the same edge that launches its req.
    assign pop = (state == ST_IDLE) && !empty;

    sync_fifo #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS),
        .WIDTH    (WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    // Handshake FSM with registered req/sent/parallel_out. req and sent are
    // single-cycle pulses; parallel_out holds until the next flit is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            req          <= 1'b0;
            sent         <= 1'b0;
            parallel_out <= '0;
        end else begin
            req  <= 1'b0;
            sent <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        parallel_out <= head;
                        req          <= 1'b1;
                        state        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // busy may already be high here; it is picked up next cycle.
                    state <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    // Return through IDLE so consecutive reqs are always spaced.
                    if (!tx_busy) begin
                        sent  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_feeder
//  Description : Self-checking bench for tx_feeder. A queue-based model of the
//                FIFO plus a link model that plays the serialiser (busy rises
//                d cycles after req and stays high for L cycles) predicts
//                every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_tx_feeder;
    import tx_feeder_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = FLIT_WIDTH;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [W-1:0] data_in;
    logic         tx_busy;
    logic         full;
    logic [2:0]   count;
    logic         overflow;
    logic         req;
    logic [W-1:0] parallel_out;
    logic         sent;

    always #5 clk = ~clk;

    tx_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .req          (req),
        .parallel_out (parallel_out),
        .tx_busy      (tx_busy),
        .sent         (sent)
    );

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] q[$];
    int           m_cnt;
    bit           m_ovf;
    bit           m_free;
    logic [W-1:0] m_hold;
    int           cyc;
    int           busy_start;
    int           busy_end;
    int           sent_at;
    int           next_d = 1;
    int           next_l = 4;
    bit           rand_link = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt      = 0;
        m_ovf      = 1'b0;
        m_free     = 1'b1;
        m_hold     = '0;
        busy_start = -1;
        busy_end   = -1;
        sent_at    = -1;
        tx_busy    = 1'b0;
    endtask

    // One clock: predict from pre-edge inputs/model, then compare after the edge.
    task automatic tick();
        bit           push;
        bit           ovf_now;
        bit           exp_req;
        bit           exp_sent;
        int           d;
        int           l;
        logic [W-1:0] din;
        logic [W-1:0] flit;
        push    = wr_en && (m_cnt < DEPTH);
        ovf_now = wr_en && (m_cnt == DEPTH);
        exp_req = m_free && (m_cnt > 0);
        din     = data_in;
        @(posedge clk);
        #1;
        cyc++;
        flit = '0;
        if (exp_req) flit = q.pop_front();
        if (push) q.push_back(din);
        m_cnt = q.size();
        if (ovf_now) m_ovf = 1'b1;
        exp_sent = (cyc == sent_at);
        chk("req", 32'(req), 32'(exp_req));
        chk("sent", 32'(sent), 32'(exp_sent));
        chk("count", 32'(count), 32'(m_cnt));
        chk("full", 32'(full), 32'(m_cnt == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (exp_req) begin
            chk("flit", 32'(parallel_out), 32'(flit));
            m_free = 1'b0;
            m_hold = flit;
            if (rand_link) begin
                d = int'($urandom_range(0, 2));
                l = int'($urandom_range(2, 6));
            end else begin
                d = next_d;
                l = next_l;
            end
            busy_start = cyc + d;
            busy_end   = busy_start + l;
            sent_at    = busy_end + 1;
        end else if (!m_free) begin
            chk("hold", 32'(parallel_out), 32'(m_hold));
        end
        if (exp_sent) m_free = 1'b1;
        tx_busy = (cyc >= busy_start) && (cyc < busy_end);
    endtask

    initial begin
        // Reset held with a write attempt: nothing may be stored.
        reset   = 1'b0;
        wr_en   = 1'b1;
        data_in = W'(9);
        cyc     = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(req), 0);
        chk("rst_sent", 32'(sent), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_pout", 32'(parallel_out), 0);
        #2;
        reset = 1'b1;
        wr_en = 1'b0;
        repeat (3) tick();

        // Single flit: busy rises 2 cycles after req for 12 cycles.
        next_d  = 2;
        next_l  = 12;
        data_in = W'(1);
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("lat_count", 32'(count), 1);
        tick();
        chk("lat_req", 32'(req), 1);
        chk("lat_flit", 32'(parallel_out), 1);
        repeat (20) tick();

        // Fill and overflow while the first flit keeps the link busy.
        next_d = 1;
        next_l = 12;
        wr_en  = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            data_in = W'(v);
            tick();
        end
        data_in = W'(255);
        tick();
        wr_en = 1'b0;
        chk("fill_full", 32'(full), 1);
        chk("fill_overflow", 32'(overflow), 1);

        // Drain: order 2,3,4,5 checked by the model on every req.
        next_l = 3;
        repeat (60) tick();
        chk("drain_count", 32'(count), 0);

        // Write on the IDLE->REQ edge: count stays at 1.
        data_in = W'(8);
        wr_en   = 1'b1;
        tick();
        data_in = W'(9);
        tick();
        wr_en = 1'b0;
        chk("simul_req", 32'(req), 1);
        chk("simul_count", 32'(count), 1);
        repeat (20) tick();
        chk("simul_drained", 32'(count), 0);

        // Reset in WAIT_DONE with two flits still queued.
        next_l = 15;
        wr_en  = 1'b1;
        for (int v = 10; v <= 12; v++) begin
            data_in = W'(v);
            tick();
        end
        wr_en = 1'b0;
        repeat (5) tick();
        chk("mid_count", 32'(count), 2);
        chk("mid_busy", 32'(tx_busy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_req_async", 32'(req), 0);
        chk("mid_pout_async", 32'(parallel_out), 0);
        chk("mid_count_async", 32'(count), 0);
        chk("mid_overflow_async", 32'(overflow), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("mid_count_held", 32'(count), 0);
        chk("mid_sent_held", 32'(sent), 0);
        #2;
        reset = 1'b1;
        repeat (20) tick();

        // Randomised traffic against a randomly timed link.
        rand_link = 1'b1;
        for (int i = 0; i < 400; i++) begin
            wr_en   = ($urandom_range(0, 9) < 4);
            data_in = W'($urandom);
            tick();
        end
        wr_en = 1'b0;
        repeat (80) tick();
        chk("final_count", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
